// File: rtl/pmp_cfg_rx_pkg.sv
// Shared definitions for the PMP configuration receiver and the capture logic.
package pmp_cfg_rx_pkg;

  // Register addresses carried in header byte bits [2:0]
  localparam logic [2:0] CFG_TRIG = 3'd0;
  localparam logic [2:0] CFG_DECL = 3'd1;
  localparam logic [2:0] CFG_DECH = 3'd2;
  localparam logic [2:0] CFG_CTRL = 3'd3;

  // Header marker bit
  localparam int unsigned HDR_FLAG = 7;

  // CTRL register bit positions
  localparam int unsigned CTRL_EDGE    = 0;
  localparam int unsigned CTRL_ARM     = 1;
  localparam int unsigned CTRL_FORCE   = 2;
  localparam int unsigned CTRL_RESTART = 3;
  localparam int unsigned CTRL_ERR_CLR = 7;

  // Decode FSM states
  typedef logic [0:0] rx_state_t;
  localparam rx_state_t StIdle     = 1'b0;
  localparam rx_state_t StWaitData = 1'b1;

  // Reset values, shared with the capture logic
  localparam logic [15:0] DECIM_RST_DEFAULT = 16'h0010;
  localparam logic [7:0]  TRIG_RST_DEFAULT  = 8'h80;

  // A decimation factor of zero is meaningless; treat it as no decimation.
  function automatic logic [15:0] clamp_decim(input logic [15:0] value);
    return (value == 16'd0) ? 16'd1 : value;
  endfunction

endpackage

// File: rtl/pmp_strobe_sync.sv
// Synchronises the asynchronous PMP pins and turns each qualified pmwrn release into a
// one-cycle strobe with the byte that was on the bus.
module pmp_strobe_sync
  import pmp_cfg_rx_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] pmd_in,
  input  logic       pmwrn,
  input  logic       pmenb,
  output logic       strb,
  output logic [7:0] data_byte
);

  logic [SYNC_STAGES-1:0] wrn_sync_q;
  logic [SYNC_STAGES-1:0] enb_sync_q;
  logic [7:0]             pmd_sync_q [SYNC_STAGES];
  logic                   wrn_prev_q;
  logic                   strb_q;
  logic [7:0]             byte_q;
  logic                   rise;

  // Rising edge of the synchronised write strobe, qualified by the synchronised enable
  always_comb begin
    rise = wrn_sync_q[SYNC_STAGES-1] & ~wrn_prev_q & enb_sync_q[SYNC_STAGES-1];
  end

  // Synchroniser chains reset to the idle bus, then edge detect and byte capture
  always_ff @(posedge clk) begin
    if (reset) begin
      wrn_sync_q <= '1;
      enb_sync_q <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        pmd_sync_q[i] <= '0;
      end
      wrn_prev_q <= 1'b1;
      strb_q     <= 1'b0;
      byte_q     <= '0;
    end else begin
      wrn_sync_q    <= {wrn_sync_q[SYNC_STAGES-2:0], pmwrn};
      enb_sync_q    <= {enb_sync_q[SYNC_STAGES-2:0], pmenb};
      pmd_sync_q[0] <= pmd_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        pmd_sync_q[i] <= pmd_sync_q[i-1];
      end
      wrn_prev_q <= wrn_sync_q[SYNC_STAGES-1];
      strb_q     <= rise;
      if (rise) begin
        byte_q <= pmd_sync_q[SYNC_STAGES-1];
      end
    end
  end

  assign strb      = strb_q;
  assign data_byte = byte_q;

endmodule

// File: rtl/pmp_cfg_rx.sv
// PIC->FPGA PMP receiver: decodes (header, data) byte pairs into capture configuration
// registers and one-cycle command pulses.
module pmp_cfg_rx
  import pmp_cfg_rx_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter logic [15:0] DECIM_RST   = DECIM_RST_DEFAULT,
  parameter logic [7:0]  TRIG_RST    = TRIG_RST_DEFAULT
) (
  input  logic        adc_dbl,
  input  logic        reset,
  input  logic [7:0]  pmd_in,
  input  logic        pmwrn,
  input  logic        pmenb,
  output logic [7:0]  trig_level,
  output logic        trig_edge,
  output logic [15:0] decim,
  output logic        armed,
  output logic        force_trig,
  output logic        restart,
  output logic        cfg_update,
  output logic        err
);

  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYC - 1);

  logic       strb;
  logic [7:0] rx_byte;

  pmp_strobe_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_strobe_sync (
    .clk      (adc_dbl),
    .reset    (reset),
    .pmd_in   (pmd_in),
    .pmwrn    (pmwrn),
    .pmenb    (pmenb),
    .strb     (strb),
    .data_byte(rx_byte)
  );

  rx_state_t   state_q, state_d;
  logic [2:0]  addr_q, addr_d;
  logic [15:0] timer_q, timer_d;
  logic [7:0]  trig_level_q, trig_level_d;
  logic        trig_edge_q, trig_edge_d;
  logic [15:0] decim_q, decim_d;
  logic [7:0]  decim_lo_q, decim_lo_d;
  logic        armed_q, armed_d;
  logic        force_trig_q, force_trig_d;
  logic        restart_q, restart_d;
  logic        cfg_update_q, cfg_update_d;
  logic        err_q, err_d;
  logic        err_set, err_clr;

  // Header/data decode, register writes and timeout supervision
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    timer_d      = timer_q;
    trig_level_d = trig_level_q;
    trig_edge_d  = trig_edge_q;
    decim_d      = decim_q;
    decim_lo_d   = decim_lo_q;
    armed_d      = armed_q;
    force_trig_d = 1'b0;
    restart_d    = 1'b0;
    cfg_update_d = 1'b0;
    err_set      = 1'b0;
    err_clr      = 1'b0;

    case (state_q)
      StIdle: begin
        if (strb) begin
          if (rx_byte[HDR_FLAG]) begin
            addr_d  = rx_byte[2:0];
            timer_d = '0;
            state_d = StWaitData;
          end else begin
            // Data byte with no header in front of it
            err_set = 1'b1;
          end
        end
      end
      StWaitData: begin
        if (strb) begin
          state_d = StIdle;
          case (addr_q)
            CFG_TRIG: begin
              trig_level_d = rx_byte;
              cfg_update_d = 1'b1;
            end
            CFG_DECL: begin
              decim_lo_d   = rx_byte;
              cfg_update_d = 1'b1;
            end
            CFG_DECH: begin
              decim_d      = clamp_decim({rx_byte, decim_lo_q});
              cfg_update_d = 1'b1;
            end
            CFG_CTRL: begin
              trig_edge_d  = rx_byte[CTRL_EDGE];
              // Restart always disarms, whatever the arm bit says
              armed_d      = rx_byte[CTRL_ARM] & ~rx_byte[CTRL_RESTART];
              force_trig_d = rx_byte[CTRL_FORCE];
              restart_d    = rx_byte[CTRL_RESTART];
              err_clr      = rx_byte[CTRL_ERR_CLR];
              cfg_update_d = 1'b1;
            end
            default: begin
              err_set = 1'b1;
            end
          endcase
        end else if (timer_q == TimeoutLast) begin
          err_set = 1'b1;
          state_d = StIdle;
        end else if (timer_q != 16'hFFFF) begin
          timer_d = timer_q + 16'd1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (err_clr) begin
      err_d = 1'b0;
    end else if (err_set) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // State and configuration registers; reset discards any pending header
  always_ff @(posedge adc_dbl) begin
    if (reset) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      timer_q      <= '0;
      trig_level_q <= TRIG_RST;
      trig_edge_q  <= 1'b0;
      decim_q      <= DECIM_RST;
      decim_lo_q   <= DECIM_RST[7:0];
      armed_q      <= 1'b0;
      force_trig_q <= 1'b0;
      restart_q    <= 1'b0;
      cfg_update_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      timer_q      <= timer_d;
      trig_level_q <= trig_level_d;
      trig_edge_q  <= trig_edge_d;
      decim_q      <= decim_d;
      decim_lo_q   <= decim_lo_d;
      armed_q      <= armed_d;
      force_trig_q <= force_trig_d;
      restart_q    <= restart_d;
      cfg_update_q <= cfg_update_d;
      err_q        <= err_d;
    end
  end

  assign trig_level = trig_level_q;
  assign trig_edge  = trig_edge_q;
  assign decim      = decim_q;
  assign armed      = armed_q;
  assign force_trig = force_trig_q;
  assign restart    = restart_q;
  assign cfg_update = cfg_update_q;
  assign err        = err_q;

endmodule

// File: tb/tb_pmp_cfg_rx.sv
// Bench for pmp_cfg_rx: directed transactions from the feature list plus random byte
// streams, all checked cycle by cycle against a transaction-level model.
module tb_pmp_cfg_rx;

  localparam int TIMEOUT = 1024;
  localparam int LAT     = 4;  // two sync stages + 2

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  pmd_in;
  logic        pmwrn;
  logic        pmenb;
  logic [7:0]  trig_level;
  logic        trig_edge;
  logic [15:0] decim;
  logic        armed;
  logic        force_trig;
  logic        restart;
  logic        cfg_update;
  logic        err;

  int vectors = 0;
  int miscompares = 0;

  pmp_cfg_rx dut (
    .adc_dbl   (clk),
    .reset     (reset),
    .pmd_in    (pmd_in),
    .pmwrn     (pmwrn),
    .pmenb     (pmenb),
    .trig_level(trig_level),
    .trig_edge (trig_edge),
    .decim     (decim),
    .armed     (armed),
    .force_trig(force_trig),
    .restart   (restart),
    .cfg_update(cfg_update),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Transaction-level model of the register file
  int m_trig, m_edge, m_decim, m_declo, m_armed, m_err, m_pending, m_addr;
  int o_trig, o_edge, o_decim, o_armed, o_err;
  int e_cfg, e_force, e_restart;

  task automatic model_reset();
    m_trig = 'h80; m_edge = 0; m_decim = 'h10; m_declo = 'h10; m_armed = 0;
    m_err = 0; m_pending = 0; m_addr = 0;
  endtask

  task automatic model_byte(input int b);
    e_cfg = 0; e_force = 0; e_restart = 0;
    if (m_pending == 0) begin
      if (b >= 128) begin
        m_pending = 1;
        m_addr = b % 8;
      end else begin
        m_err = 1;
      end
    end else begin
      m_pending = 0;
      if (m_addr == 0) begin
        m_trig = b; e_cfg = 1;
      end else if (m_addr == 1) begin
        m_declo = b; e_cfg = 1;
      end else if (m_addr == 2) begin
        m_decim = b * 256 + m_declo;
        if (m_decim == 0) m_decim = 1;
        e_cfg = 1;
      end else if (m_addr == 3) begin
        e_cfg = 1;
        m_edge = b % 2;
        e_force = (b / 4) % 2;
        e_restart = (b / 8) % 2;
        m_armed = (e_restart == 1) ? 0 : (b / 2) % 2;
        if (b >= 128) m_err = 0;
      end else begin
        m_err = 1;
      end
    end
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input bit use_new, input int cfg, input int frc, input int rst);
    check("trig_level", int'(trig_level), use_new ? m_trig  : o_trig);
    check("trig_edge",  int'(trig_edge),  use_new ? m_edge  : o_edge);
    check("decim",      int'(decim),      use_new ? m_decim : o_decim);
    check("armed",      int'(armed),      use_new ? m_armed : o_armed);
    check("err",        int'(err),        use_new ? m_err   : o_err);
    check("cfg_update", int'(cfg_update), cfg);
    check("force_trig", int'(force_trig), frc);
    check("restart",    int'(restart),    rst);
  endtask

  // One PMP write; outputs are checked every cycle after pmwrn release, so the update must
  // land exactly LAT cycles after the pin edge and pulses must last one cycle.
  task automatic pmp_write(input logic [7:0] b, input logic en);
    @(negedge clk);
    pmd_in = b; pmenb = en; pmwrn = 1'b0;
    repeat (3) @(negedge clk);
    pmwrn = 1'b1;
    o_trig = m_trig; o_edge = m_edge; o_decim = m_decim; o_armed = m_armed; o_err = m_err;
    e_cfg = 0; e_force = 0; e_restart = 0;
    if (en) model_byte(int'(b));
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (k == LAT) check_state(1'b1, e_cfg, e_force, e_restart);
      else check_state(k > LAT, 0, 0, 0);
    end
    pmenb = 1'b0;
  endtask

  task automatic check_now();
    o_trig = m_trig; o_edge = m_edge; o_decim = m_decim; o_armed = m_armed; o_err = m_err;
    check_state(1'b1, 0, 0, 0);
  endtask

  initial begin
    int b, kind;
    reset = 1'b1; pmd_in = 8'h00; pmwrn = 1'b1; pmenb = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check_now();

    // Trigger level
    pmp_write(8'h80, 1'b1); pmp_write(8'h40, 1'b1);
    // Decimation staging, atomic update, zero clamp
    pmp_write(8'h81, 1'b1); pmp_write(8'h34, 1'b1);
    pmp_write(8'h82, 1'b1); pmp_write(8'h12, 1'b1);
    pmp_write(8'h81, 1'b1); pmp_write(8'h00, 1'b1);
    pmp_write(8'h82, 1'b1); pmp_write(8'h00, 1'b1);
    // DECH alone reuses the last low byte
    pmp_write(8'h82, 1'b1); pmp_write(8'h05, 1'b1);
    // CTRL: edge/arm/force, then restart overriding arm
    pmp_write(8'h83, 1'b1); pmp_write(8'h07, 1'b1);
    pmp_write(8'h83, 1'b1); pmp_write(8'h0A, 1'b1);
    // Unmapped address, then error clear
    pmp_write(8'h85, 1'b1); pmp_write(8'hAA, 1'b1);
    pmp_write(8'h83, 1'b1); pmp_write(8'h80, 1'b1);

    // Timeout: header processed at cycle LAT after release; expires TIMEOUT cycles later
    pmp_write(8'h80, 1'b1);
    repeat (TIMEOUT - 14) @(posedge clk);
    #1; check_now();
    repeat (10) @(posedge clk);
    #1;
    m_pending = 0; m_err = 1;
    check_now();
    pmp_write(8'h40, 1'b1);

    // Reset mid-transaction discards the header
    pmp_write(8'h80, 1'b1);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    model_reset();
    @(posedge clk); #1; check_now();
    pmp_write(8'h80, 1'b1); pmp_write(8'h11, 1'b1);

    // Writes with pmenb low are ignored
    pmp_write(8'h81, 1'b0);
    pmp_write(8'h80, 1'b1); pmp_write(8'h33, 1'b1);

    // Random byte streams
    for (int i = 0; i < 160; i++) begin
      kind = int'($urandom_range(0, 9));
      b = int'($urandom_range(0, 255));
      if (kind == 0) begin
        pmp_write(8'(b), 1'b0);
      end else if (kind == 1 || m_pending == 1) begin
        pmp_write(8'(b), 1'b1);
      end else begin
        b = 128 + ((kind < 8) ? int'($urandom_range(0, 3)) : int'($urandom_range(4, 7)));
        pmp_write(8'(b), 1'b1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
